// File: rtl/aes_subbytes_engine_if.sv
// aes_subbytes_engine_if: request/result bundle between the round controller and the SubBytes engine.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface aes_subbytes_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   modport master (
      output in_valid, in_state, in_inv, out_ready,
      input  in_ready, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, in_inv, out_ready,
      output in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/aes_subbytes_engine.sv
// aes_subbytes_engine: buffered AES-128 state, LANES bytes per cycle through S-box or inverse S-box.
// Latency: 16/LANES cycles accept-to-out_valid; 16/LANES+1 when AES_SBOX_PIPE_EN is defined.
// Backpressure: in_ready only while IDLE; result held stable in DONE until out_ready.
module aes_subbytes_engine #(
   parameter int LANES       = 4,   // 1, 2, 4, 8 or 16
   parameter int STATE_BYTES = 16   // AES-128 only
) (
   input logic                  clk,
   input logic                  rst_n,
   aes_subbytes_engine_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Byte index of the final group; the step wraps the 4-bit index back to 0 after it.
   localparam logic [3:0] LAST_IDX = 4'(STATE_BYTES - LANES);
   localparam logic [3:0] STEP     = 4'(LANES);

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      return inv ? INV_SBOX[b] : SBOX[b];
   endfunction

   state_t     state_q, state_d;
   logic [7:0] buf_q [STATE_BYTES];   // byte 0 is in_state[127:120]
   logic [3:0] idx_q;
   logic       mode_q;
   logic       last_cycle;
   logic [7:0] lut_dat [LANES];

   // One S-box lookup per lane on the current group of the buffer.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lut_dat[l] = sub_byte(buf_q[idx_q + 4'(l)], mode_q);
   end

`ifdef AES_SBOX_PIPE_EN
   logic       pipe_vld_q;
   logic       drain_q;
   logic [3:0] pipe_idx_q;
   logic [7:0] pipe_dat_q [LANES];

   // The last BUSY cycle only writes back the group still sitting in the pipe register.
   assign last_cycle = drain_q;

   // Lookup register stage: captures each issued group and where it belongs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= 1'b0;
         drain_q    <= 1'b0;
         pipe_idx_q <= '0;
         for (int l = 0; l < LANES; l++) pipe_dat_q[l] <= '0;
      end else begin
         pipe_vld_q <= (state_q == BUSY) && !drain_q;
         drain_q    <= (state_q == BUSY) && !drain_q && (idx_q == LAST_IDX);
         pipe_idx_q <= idx_q;
         for (int l = 0; l < LANES; l++) pipe_dat_q[l] <= lut_dat[l];
      end
   end
`else
   assign last_cycle = (idx_q == LAST_IDX);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = BUSY;
         end
         BUSY: begin
            bus.busy = 1'b1;
            if (last_cycle) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Only a finished state is ever visible on out_state.
   always_comb begin
      bus.out_state = '0;
      if (state_q == DONE) begin
         for (int i = 0; i < STATE_BYTES; i++) bus.out_state[8*STATE_BYTES-1-8*i -: 8] = buf_q[i];
      end
   end

   // Buffer load on accept, group write-back while BUSY, index walk with wrap to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STATE_BYTES; i++) buf_q[i] <= '0;
         idx_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < STATE_BYTES; i++) buf_q[i] <= bus.in_state[8*STATE_BYTES-1-8*i -: 8];
                  mode_q <= bus.in_inv;
                  idx_q  <= '0;
               end
            end
            BUSY: begin
`ifdef AES_SBOX_PIPE_EN
               if (!drain_q) idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + STEP;
               if (pipe_vld_q) begin
                  for (int l = 0; l < LANES; l++) buf_q[pipe_idx_q + 4'(l)] <= pipe_dat_q[l];
               end
`else
               idx_q <= last_cycle ? 4'd0 : idx_q + STEP;
               for (int l = 0; l < LANES; l++) buf_q[idx_q + 4'(l)] <= lut_dat[l];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// tb_aes_subbytes_engine: directed bench for three engine widths (LANES 4, 1, 16).
// Expected bytes come from an algebraic GF(2^8) S-box model built at time zero.
// Latency expectations follow AES_SBOX_PIPE_EN when the bench is built with it.
module tb_aes_subbytes_engine;

`ifdef AES_SBOX_PIPE_EN
   localparam int PIPE_EXTRA = 1;
`else
   localparam int PIPE_EXTRA = 0;
`endif

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;

   logic clk;
   logic rst_n;

   // Per-instance drive and monitor: index 0 = LANES 4, 1 = LANES 1, 2 = LANES 16.
   logic         vld  [3];
   logic [127:0] st   [3];
   logic         inv  [3];
   logic         ordy [3];
   logic         ov   [3];
   logic         irdy [3];
   logic         bsy  [3];
   logic [127:0] ost  [3];
   int           lanes_of [3] = '{4, 1, 16};

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   int errors = 0;
   int checks = 0;

   aes_subbytes_engine_if if_l4 ();
   aes_subbytes_engine_if if_l1 ();
   aes_subbytes_engine_if if_l16 ();

   assign if_l4.in_valid   = vld[0];
   assign if_l4.in_state   = st[0];
   assign if_l4.in_inv     = inv[0];
   assign if_l4.out_ready  = ordy[0];
   assign ov[0]            = if_l4.out_valid;
   assign irdy[0]          = if_l4.in_ready;
   assign bsy[0]           = if_l4.busy;
   assign ost[0]           = if_l4.out_state;

   assign if_l1.in_valid   = vld[1];
   assign if_l1.in_state   = st[1];
   assign if_l1.in_inv     = inv[1];
   assign if_l1.out_ready  = ordy[1];
   assign ov[1]            = if_l1.out_valid;
   assign irdy[1]          = if_l1.in_ready;
   assign bsy[1]           = if_l1.busy;
   assign ost[1]           = if_l1.out_state;

   assign if_l16.in_valid  = vld[2];
   assign if_l16.in_state  = st[2];
   assign if_l16.in_inv    = inv[2];
   assign if_l16.out_ready = ordy[2];
   assign ov[2]            = if_l16.out_valid;
   assign irdy[2]          = if_l16.in_ready;
   assign bsy[2]           = if_l16.busy;
   assign ost[2]           = if_l16.out_state;

   aes_subbytes_engine #(.LANES(4))  u_dut_l4  (.clk(clk), .rst_n(rst_n), .bus(if_l4));
   aes_subbytes_engine #(.LANES(1))  u_dut_l1  (.clk(clk), .rst_n(rst_n), .bus(if_l1));
   aes_subbytes_engine #(.LANES(16)) u_dut_l16 (.clk(clk), .rst_n(rst_n), .bus(if_l16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] x);
      logic [7:0] iv;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
      return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Hand one state to instance d with out_ready high; returns result and accept-to-out_valid cycles.
   task automatic run_state(input int d, input logic [127:0] s, input logic m,
                            output logic [127:0] res, output int lat);
      int n;
      n = 0;
      while (!irdy[d] && n < 40) begin cyc(); n++; end
      vld[d] = 1'b1; st[d] = s; inv[d] = m; ordy[d] = 1'b1;
      cyc();
      vld[d] = 1'b0; inv[d] = ~m; st[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat = 0;
      while (!ov[d] && lat < 40) begin cyc(); lat++; end
      res = ost[d];
      cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0; st[d] = '0; inv[d] = 1'b0; ordy[d] = 1'b0;
      end
      cyc(); cyc();
      for (int d = 0; d < 3; d++) begin
         checks++; if (irdy[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, irdy[d]); end
         checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov[d]); end
         checks++; if (bsy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, bsy[d]); end
         checks++; if (ost[d] !== 128'h0) begin errors++; $display("FAIL reset_out_state[%0d]: got %h want 0", d, ost[d]); end
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_zero_state();
      logic [127:0] res;
      int lat;
      run_state(0, 128'h0, 1'b0, res, lat);
      checks++; if (lat !== 4 + PIPE_EXTRA) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, 4 + PIPE_EXTRA); end
      checks++; if (res !== ALL_63) begin errors++; $display("FAIL zero_result: got %h want %h", res, ALL_63); end
   endtask

   task automatic test_fips_round_trip();
      logic [127:0] res, back;
      int lat;
      run_state(0, FIPS_IN, 1'b0, res, lat);
      checks++; if (lat !== 4 + PIPE_EXTRA) begin errors++; $display("FAIL fips_fwd_latency: got %0d want %0d", lat, 4 + PIPE_EXTRA); end
      checks++; if (res !== FIPS_OUT) begin errors++; $display("FAIL fips_fwd: got %h want %h", res, FIPS_OUT); end
      run_state(0, res, 1'b1, back, lat);
      checks++; if (lat !== 4 + PIPE_EXTRA) begin errors++; $display("FAIL fips_inv_latency: got %0d want %0d", lat, 4 + PIPE_EXTRA); end
      checks++; if (back !== FIPS_IN) begin errors++; $display("FAIL fips_inv: got %h want %h", back, FIPS_IN); end
   endtask

   task automatic test_sweep(input int d);
      logic [127:0] s, res, exp;
      int lat, want_lat;
      want_lat = 16 / lanes_of[d] + PIPE_EXTRA;
      for (int m = 0; m < 2; m++) begin
         for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
               s[127-8*i -: 8]   = 8'(blk * 16 + i);
               exp[127-8*i -: 8] = (m == 0) ? fwd_tab[blk * 16 + i] : inv_tab[blk * 16 + i];
            end
            run_state(d, s, m[0], res, lat);
            checks++; if (lat !== want_lat) begin errors++; $display("FAIL sweep_latency[L%0d m%0d b%0d]: got %0d want %0d", lanes_of[d], m, blk, lat, want_lat); end
            checks++; if (res !== exp) begin errors++; $display("FAIL sweep[L%0d m%0d b%0d]: got %h want %h", lanes_of[d], m, blk, res, exp); end
            if (m == 0 && blk == 5) begin
               checks++; if (res[103:96] !== 8'hed) begin errors++; $display("FAIL sbox_53[L%0d]: got %h want ed", lanes_of[d], res[103:96]); end
            end
            if (m == 1 && blk == 14) begin
               checks++; if (res[23:16] !== 8'h53) begin errors++; $display("FAIL inv_sbox_ed[L%0d]: got %h want 53", lanes_of[d], res[23:16]); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] held;
      int n;
      n = 0;
      while (!irdy[0] && n < 40) begin cyc(); n++; end
      vld[0] = 1'b1; st[0] = FIPS_IN; inv[0] = 1'b0; ordy[0] = 1'b0;
      cyc();
      n = 0;
      while (!ov[0] && n < 40) begin
         vld[0] = 1'b1; st[0] = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000; inv[0] = 1'b1;
         cyc(); n++;
      end
      checks++; if (n !== 4 + PIPE_EXTRA) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, 4 + PIPE_EXTRA); end
      held = ost[0];
      checks++; if (held !== FIPS_OUT) begin errors++; $display("FAIL bp_result: got %h want %h", held, FIPS_OUT); end
      for (int k = 0; k < 10; k++) begin
         vld[0] = k[0];
         cyc();
         checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, ov[0]); end
         checks++; if (ost[0] !== FIPS_OUT) begin errors++; $display("FAIL bp_out_state[%0d]: got %h want %h", k, ost[0], FIPS_OUT); end
         checks++; if (irdy[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, irdy[0]); end
      end
      vld[0] = 1'b0; ordy[0] = 1'b1;
      cyc();
      checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", ov[0]); end
      checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", irdy[0]); end
      cyc();
      checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL bp_no_spurious_accept: busy %b want 0", bsy[0]); end
   endtask

   task automatic test_reset_mid_busy();
      logic [127:0] res;
      int lat, seen;
      vld[0] = 1'b1; st[0] = FIPS_IN; inv[0] = 1'b0; ordy[0] = 1'b1;
      cyc();
      vld[0] = 1'b0;
      cyc(); cyc();
      checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", bsy[0]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", bsy[0]); end
      checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid: got %b want 0", ov[0]); end
      checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready: got %b want 1", irdy[0]); end
      checks++; if (ost[0] !== 128'h0) begin errors++; $display("FAIL rst_async_out_state: got %h want 0", ost[0]); end
      cyc();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (ov[0] || bsy[0]) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_nothing_emitted: %0d active cycles, want 0", seen); end
      run_state(0, 128'h0, 1'b0, res, lat);
      checks++; if (lat !== 4 + PIPE_EXTRA) begin errors++; $display("FAIL rst_recover_latency: got %0d want %0d", lat, 4 + PIPE_EXTRA); end
      checks++; if (res !== ALL_63) begin errors++; $display("FAIL rst_recover_result: got %h want %h", res, ALL_63); end
   endtask

   initial begin
      for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_model(8'(x));
      for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
      test_reset();
      test_zero_state();
      test_fips_round_trip();
      test_sweep(1);
      test_sweep(2);
      test_backpressure();
      test_reset_mid_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
